// File: rtl/serial_sub_ctrl_if.sv
// ============================================================================
// Module   : serial_sub_ctrl_if
// Purpose  : Request/response bundle for the bit-serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
endinterface

`default_nettype wire

// File: rtl/serial_sub_ctrl.sv
// ============================================================================
// Module   : serial_sub_ctrl
// Purpose  : Bit-serial (LSB first) unsigned subtractor, one bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  serial_sub_ctrl_if.slave bus
);

  localparam int             CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST  = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q;
  logic [WIDTH-2:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [CW-1:0]    cnt_q;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  logic             a_bit, b_bit;
  logic             hs1_d, hs1_br;
  logic             hs2_d, hs2_br;
  logic             last_bit;
  logic             busy_w, done_w;

  // Full subtractor = two half-subtractor stages; borrows OR together.
  always_comb begin
    a_bit    = a_sh_q[0];
    b_bit    = b_sh_q[0];
    hs1_d    = a_bit ^ b_bit;
    hs1_br   = ~a_bit & b_bit;
    hs2_d    = hs1_d ^ br_q;
    hs2_br   = ~hs1_d & br_q;
    br_d     = hs1_br | hs2_br;
    res_d    = {hs2_d, res_q};
    last_bit = (cnt_q == LAST);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy_w = 1'b0;
    done_w = 1'b0;
    case (state_q)
      SHIFT:   busy_w = 1'b1;
      DONE:    done_w = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operands captured only on the accepting edge, so later
  // changes on a/b cannot disturb an operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_sh_q <= bus.a;
            b_sh_q <= bus.b;
            br_q   <= 1'b0;
            cnt_q  <= '0;
          end
        end
        SHIFT: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          br_q   <= br_d;
          res_q  <= res_d[WIDTH-1:1];
          cnt_q  <= cnt_q + CW'(1);
          if (last_bit) begin
            diff_q   <= res_d;
            borrow_q <= br_d;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = busy_w;
  assign bus.done       = done_w;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
// ============================================================================
// Module   : tb_serial_sub_ctrl
// Purpose  : Self-checking bench for serial_sub_ctrl (WIDTH = 8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_sub_ctrl;

  localparam int WIDTH = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       br;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic       br;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  serial_sub_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [7:0] last_d  = 8'h00;
  logic       last_br = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      check("done_has_expectation", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("diff", 32'(bus.diff), 32'(mon_e.d));
        check("borrow_out", 32'(bus.borrow_out), 32'(mon_e.br));
      end
    end
  end

  // One operation; inputs are scrambled while it runs, and a spurious start
  // with other operands is injected at iteration inject_at (if >= 0).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb, input int inject_at);
    exp_t e;
    int   n_busy;
    logic hold_ok;
    logic got;
    e.d = ed;
    e.br = eb;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 8'($urandom); bus.b = 8'($urandom);
    n_busy = 0; hold_ok = 1'b1; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (bus.busy === 1'b1) n_busy++;
      if (bus.diff !== last_d || bus.borrow_out !== last_br) hold_ok = 1'b0;
      @(negedge clk);
      bus.start = (i == inject_at) ? 1'b1 : 1'b0;
      bus.a = (i == inject_at) ? 8'd1 : 8'($urandom);
      bus.b = (i == inject_at) ? 8'd2 : 8'($urandom);
    end
    bus.start = 1'b0;
    check("done_seen", 32'(got), 1);
    check("busy_cycles", 32'(n_busy), 8);
    check("prev_result_held", 32'(hold_ok), 1);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 0);
    last_d = ed;
    last_br = eb;
  endtask

  vec_t vecs[7];

  initial begin
    int   cyc;
    int   done_cyc[3];
    int   n_done;
    exp_t e;

    vecs[0] = '{8'd9,   8'd5,   8'h04, 1'b0};
    vecs[1] = '{8'h00,  8'h01,  8'hFF, 1'b1};
    vecs[2] = '{8'h80,  8'h7F,  8'h01, 1'b0};
    vecs[3] = '{8'hA5,  8'hA5,  8'h00, 1'b0};
    vecs[4] = '{8'h00,  8'hFF,  8'h01, 1'b1};
    vecs[5] = '{8'hFF,  8'h00,  8'hFF, 1'b0};
    vecs[6] = '{8'd3,   8'd7,   8'hFC, 1'b1};

    // Reset with random inputs, checked before any clock edge
    rst_n = 1'b0;
    bus.start = 1'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_diff", 32'(bus.diff), 0);
    check("rst_borrow", 32'(bus.borrow_out), 0);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br, -1);

    // Start requests during SHIFT are ignored
    run_op(8'd200, 8'd100, 8'd100, 1'b0, 2);
    repeat (12) @(negedge clk);

    // Held start: back-to-back operations every WIDTH+2 cycles
    e.d = 8'hFC; e.br = 1'b1;
    repeat (3) sb.push_back(e);
    @(negedge clk);
    bus.a = 8'd3; bus.b = 8'd7; bus.start = 1'b1;
    n_done = 0;
    cyc = 0;
    while (n_done < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.done === 1'b1) begin
        done_cyc[n_done] = cyc;
        n_done++;
      end
    end
    bus.start = 1'b0;
    check("held_done_count", 32'(n_done), 3);
    if (n_done == 3) begin
      check("held_period_1", 32'(done_cyc[1] - done_cyc[0]), 10);
      check("held_period_2", 32'(done_cyc[2] - done_cyc[1]), 10);
    end
    @(negedge clk);
    @(negedge clk);
    check("held_released_idle", 32'(bus.busy), 0);
    last_d = 8'hFC; last_br = 1'b1;

    // Reset mid-SHIFT aborts without a done pulse
    @(negedge clk);
    bus.a = 8'd77; bus.b = 8'd11; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy_before", 32'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_diff", 32'(bus.diff), 0);
    check("abort_borrow", 32'(bus.borrow_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    last_d = 8'h00; last_br = 1'b0;
    run_op(8'd50, 8'd20, 8'd30, 1'b0, -1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: start  input  1  request one subtraction; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  minuend; captured on the accepting edge only.
REQ-006 Port: b  input  WIDTH  subtrahend; captured on the accepting edge only.
REQ-007 Port: busy  output  1  high while bits are being processed (state SHIFT).
REQ-008 Port: done  output  1  one-cycle pulse; result valid from this cycle.
REQ-009 Port: diff  output  WIDTH  registered result, (a - b) mod 2^WIDTH.
REQ-010 Port: borrow_out  output  1  registered final borrow; 1 when a < b (unsigned).

Function
REQ-011 The block SHALL compute the result bit-serially, LSB first, one bit per clock, through a single full-subtractor cell built from two half-subtractor stages plus a borrow flip-flop.
REQ-012 FSM states SHALL be IDLE, SHIFT, DONE; no other reachable states.
REQ-013 IDLE -> SHIFT on an edge with start=1: load a and b into internal shift registers, clear the borrow flip-flop, clear the bit counter; IDLE holds while start=0.
REQ-014 In SHIFT, each edge SHALL process bit i: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br); d shifts into an internal result register; counter increments.
REQ-015 SHIFT -> DONE on the edge processing bit WIDTH-1; that same edge SHALL copy the completed internal result to diff and the final br to borrow_out.
REQ-016 DONE -> IDLE unconditionally on the next edge.
REQ-017 busy SHALL be 1 exactly in SHIFT (WIDTH cycles); done SHALL be 1 exactly in DONE (one cycle).
REQ-018 Latency: start sampled at edge k -> done high in the cycle following edge k+WIDTH; minimum start-to-start period WIDTH+2 cycles.
REQ-019 start SHALL be ignored in SHIFT and DONE; a held-high start is accepted again only on the first edge after returning to IDLE.
REQ-020 Changes on a and b outside the accepting edge SHALL NOT affect the result in progress.
REQ-021 diff and borrow_out SHALL hold the last completed result through IDLE and SHIFT of the next operation; they change only on SHIFT -> DONE.
REQ-022 Boundary: a = b gives diff = 0, borrow_out = 0; a = 0, b = 2^WIDTH-1 gives diff = 1, borrow_out = 1.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, busy = 0, done = 0, diff = 0, borrow_out = 0, and clear counter, borrow flip-flop and shift registers, independent of clk.
REQ-024 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; the first edge with rst_n high and start=1 begins a fresh operation.

Verification (WIDTH = 8)
REQ-025 Assert rst_n=0 with random inputs -> busy=0, done=0, diff=8'h00, borrow_out=0 without any clock edge.
REQ-026 a=8'd9, b=8'd5, start pulse at edge k -> busy high 8 cycles, done high exactly one cycle after edge k+8, diff=8'h04, borrow_out=0.
REQ-027 a=8'h00, b=8'h01 -> diff=8'hFF, borrow_out=1; then a=8'h80, b=8'h7F -> diff=8'h01, borrow_out=0; then a=b=8'hA5 -> diff=8'h00, borrow_out=0.
REQ-028 Start a=8'd200, b=8'd100; during SHIFT pulse start with a=8'd1, b=8'd2 and toggle a/b -> ignored, diff=8'd100, borrow_out=0, previous diff held until DONE.
REQ-029 start held high continuously with a=8'd3, b=8'd7 -> done pulses every 10 cycles, each with diff=8'hFC, borrow_out=1.
REQ-030 rst_n low after 3 SHIFT cycles -> busy drops immediately, no done pulse, diff=8'h00; after release, a=8'd50, b=8'd20 completes with diff=8'd30.
